// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the one-hot select pins of a 3-input, 4-bit mux.
// A holder keeps the mux while it requests, but only MAX_HOLD cycles if others wait.
module mux_sel_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    output logic             sel1,
    output logic             sel2,
    output logic             sel3,
    output logic [1:0]       owner,
    output logic             busy,
    output logic             switch_p,
    output logic [CNT_W-1:0] tenure
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [1:0]       last_grant_q, last_grant_d;
    logic [CNT_W-1:0] tenure_q, tenure_d;
    logic             switch_q, switch_d;

    logic [2:0]       others;
    logic [2:0]       pick_src;
    logic [1:0]       pick;
    logic             holder_req;

    // First requester in r found when searching from lg+1 with wrap-around.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] lg);
        logic [1:0] c0, c1, c2;
        c0 = (lg >= 2'd2) ? 2'd0 : 2'(lg + 2'd1);
        c1 = (c0 == 2'd2) ? 2'd0 : 2'(c0 + 2'd1);
        c2 = (c1 == 2'd2) ? 2'd0 : 2'(c1 + 2'd1);
        if (r[c0])      return c0;
        else if (r[c1]) return c1;
        else            return c2;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 3'b000;
            last_grant_q <= 2'd2;
            tenure_q     <= '0;
            switch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            tenure_q     <= tenure_d;
            switch_q     <= switch_d;
        end
    end

    // In GRANT the holder is always last_grant_q, so it is masked out of the search.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        tenure_d     = tenure_q;
        switch_d     = 1'b0;
        others       = req & ~(3'(3'b001 << last_grant_q));
        holder_req   = req[last_grant_q];
        pick_src     = (state_q == GRANT) ? others : req;
        pick         = rr_pick(pick_src, last_grant_q);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d      = GRANT;
                    sel_d        = 3'(3'b001 << pick);
                    last_grant_d = pick;
                    tenure_d     = CNT_W'(1);
                    switch_d     = 1'b1;
                end else begin
                    sel_d    = 3'b000;
                    tenure_d = '0;
                end
            end
            GRANT: begin
                if (holder_req && ((tenure_q < MAX_T) || (others == 3'b000))) begin
                    if (tenure_q < MAX_T) begin
                        tenure_d = tenure_q + CNT_W'(1);
                    end
                end else if (|others) begin
                    sel_d        = 3'(3'b001 << pick);
                    last_grant_d = pick;
                    tenure_d     = CNT_W'(1);
                    switch_d     = 1'b1;
                end else begin
                    state_d  = IDLE;
                    sel_d    = 3'b000;
                    tenure_d = '0;
                    switch_d = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                sel_d    = 3'b000;
                tenure_d = '0;
            end
        endcase
    end

    always_comb begin
        sel1     = sel_q[0];
        sel2     = sel_q[1];
        sel3     = sel_q[2];
        busy     = |sel_q;
        switch_p = switch_q;
        tenure   = tenure_q;
        case (sel_q)
            3'b001:  owner = 2'd1;
            3'b010:  owner = 2'd2;
            3'b100:  owner = 2'd3;
            default: owner = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed plan steps followed by random
// requests, every cycle compared against a behavioural round-robin model.
module tb_mux_sel_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       req = 3'b000;
    logic             sel1, sel2, sel3, busy, switch_p;
    logic [1:0]       owner;
    logic [CNT_W-1:0] tenure;

    int testsRun  = 0;
    int failCount = 0;

    // Reference model: holder is the granted requester index, -1 when idle.
    int mHolder    = -1;
    int mLastGrant = 2;
    int mTenure    = 0;
    int mSwitch    = 0;

    mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req(req),
        .sel1(sel1), .sel2(sel2), .sel3(sel3),
        .owner(owner), .busy(busy), .switch_p(switch_p), .tenure(tenure)
    );

    always #5 clk = ~clk;

    function automatic int pickRR(input int r, input int lg);
        for (int i = 1; i <= 3; i++) begin
            if (((r >> ((lg + i) % 3)) & 1) == 1) return (lg + i) % 3;
        end
        return -1;
    endfunction

    task automatic modelStep(input int r, input bit rs);
        int prev, others;
        if (rs) begin
            mHolder = -1; mLastGrant = 2; mTenure = 0; mSwitch = 0;
            return;
        end
        prev = mHolder;
        if (mHolder < 0) begin
            if (r != 0) mHolder = pickRR(r, mLastGrant);
        end else begin
            others = r & ~(1 << mHolder);
            if (((r >> mHolder) & 1) == 1 && (mTenure < MAX_HOLD || others == 0)) begin
                if (mTenure < MAX_HOLD) mTenure++;
            end else if (others != 0) begin
                mHolder = pickRR(others, mHolder);
            end else begin
                mHolder = -1;
            end
        end
        if (mHolder != prev && mHolder >= 0) begin
            mLastGrant = mHolder;
            mTenure = 1;
        end
        if (mHolder < 0) mTenure = 0;
        mSwitch = (mHolder != prev) ? 1 : 0;
    endtask

    task automatic checkEq(input string tag, input int obs, input int exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int expSel;
        expSel = (mHolder < 0) ? 0 : (1 << mHolder);
        checkEq({tag, " sels"}, int'({sel3, sel2, sel1}), expSel);
        checkEq({tag, " owner"}, int'(owner), mHolder + 1);
        checkEq({tag, " busy"}, int'(busy), (mHolder >= 0) ? 1 : 0);
        checkEq({tag, " switch_p"}, int'(switch_p), mSwitch);
        checkEq({tag, " tenure"}, int'(tenure), mTenure);
        checkEq({tag, " onehot0"}, int'($onehot0({sel3, sel2, sel1})), 1);
    endtask

    task automatic applyStimulus(input logic [2:0] r, input bit rs, input string tag);
        @(negedge clk);
        req = r;
        rst = rs;
        @(posedge clk);
        modelStep(int'(r), rs);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        // Test 1: single requester holds beyond MAX_HOLD, then releases.
        applyStimulus(3'b000, 1'b1, "reset");
        applyStimulus(3'b000, 1'b1, "reset");
        checkEq("reset owner const", int'(owner), 0);
        checkEq("reset tenure const", int'(tenure), 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(3'b010, 1'b0, "single");
            if (i == 0) begin
                checkEq("single first sel2", int'(sel2), 1);
                checkEq("single first switch", int'(switch_p), 1);
            end
            checkEq("single tenure seq", int'(tenure), (i < 4) ? i + 1 : 4);
        end
        applyStimulus(3'b000, 1'b0, "release");
        checkEq("release owner", int'(owner), 0);
        checkEq("release switch", int'(switch_p), 1);
        applyStimulus(3'b000, 1'b0, "idle");

        // Test 2: full contention rotates 0,1,2,0 every MAX_HOLD cycles.
        applyStimulus(3'b000, 1'b1, "reset2");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(3'b111, 1'b0, "contend");
            checkEq("contend owner seq", int'(owner), ((i / MAX_HOLD) % 3) + 1);
        end

        // Test 3: early release hands off with no idle gap.
        applyStimulus(3'b000, 1'b1, "reset3");
        applyStimulus(3'b011, 1'b0, "early");
        applyStimulus(3'b011, 1'b0, "early");
        applyStimulus(3'b010, 1'b0, "handoff");
        checkEq("handoff owner", int'(owner), 2);
        checkEq("handoff tenure", int'(tenure), 1);
        applyStimulus(3'b010, 1'b0, "handoff hold");

        // Test 4: pointer wraps from requester 2 to requester 0.
        applyStimulus(3'b000, 1'b0, "wrap idle");
        applyStimulus(3'b100, 1'b0, "wrap r2");
        applyStimulus(3'b000, 1'b0, "wrap rel");
        applyStimulus(3'b101, 1'b0, "wrap both");
        checkEq("wrap owner", int'(owner), 1);

        // Test 5: reset mid-tenure drops the grant, regrant from idle afterwards.
        applyStimulus(3'b000, 1'b1, "reset5");
        applyStimulus(3'b100, 1'b0, "mid");
        applyStimulus(3'b100, 1'b0, "mid");
        checkEq("mid tenure", int'(tenure), 2);
        applyStimulus(3'b100, 1'b1, "mid reset");
        checkEq("mid reset owner", int'(owner), 0);
        applyStimulus(3'b100, 1'b0, "regrant");
        checkEq("regrant owner", int'(owner), 3);
        checkEq("regrant switch", int'(switch_p), 1);

        // Test 6: sweep every request pattern.
        for (int v = 0; v < 8; v++) begin
            for (int c = 0; c < 8; c++) applyStimulus(3'(v), 1'b0, "sweep");
        end

        // Random phase: sticky requests with occasional toggles and rare resets.
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            applyStimulus(r, ($urandom_range(0, 99) == 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
